// File: rtl/fb_reader_if.sv
// Pixel stream from the framebuffer scan-out reader to the display driver.
// The reader drives the master side; the consumer drives ready.
interface fb_reader_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic              sof;
   logic              eol;

   modport master (output data, output valid, output sof, output eol, input ready);
   modport slave  (input data, input valid, input sof, input eol, output ready);
endinterface

// File: rtl/fb_reader.sv
// Raster scan-out of the framebuffer starting at a programmable scroll row,
// two-cycle reads shared politely with the writer, 2-entry FIFO toward the LCD.
module fb_reader #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        scroll_row,
   input  logic              ram_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_hold,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              frame_done,
   fb_reader_if.master       pix
);

   localparam int COL_W  = $clog2(WIDTH);
   localparam int LINE_W = $clog2(HEIGHT);
   localparam int ENT_W  = DATA_W + 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   // Row-to-address as a sum of shifted copies of row, one per set bit of WIDTH.
   function automatic logic [ADDR_W-1:0] row_base_of(input logic [7:0] row);
      logic [ADDR_W-1:0] acc;
      acc = {ADDR_W{1'b0}};
      for (int b = 0; b < 32; b++) begin
         if (WIDTH[b]) begin
            acc = acc + (ADDR_W'(row) << b);
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

   state_t              state_r;
   logic [COL_W-1:0]    col_r;
   logic [LINE_W-1:0]   line_r;
   logic [7:0]          row_r;
   logic [ADDR_W-1:0]   row_base_r;
   logic [ADDR_W-1:0]   addr_r;
   logic                ram_hold_r;
   logic                busy_r;
   logic                done_r;

   logic [ENT_W-1:0]    fifo_mem_r [2];
   logic                wr_ptr_r;
   logic                rd_ptr_r;
   logic [1:0]          count_r;

   logic [7:0]          start_row_s;
   logic                col_last_s;
   logic                row_last_s;
   logic                frame_last_s;
   logic                issue_ok_s;
   logic                push_s;
   logic                pop_s;
   logic                sof_s;
   logic [ENT_W-1:0]    head_s;

   assign start_row_s  = (scroll_row >= 8'(HEIGHT)) ? 8'd0 : scroll_row;
   assign col_last_s   = (col_r == COL_W'(WIDTH - 1));
   assign row_last_s   = (row_r == 8'(HEIGHT - 1));
   assign frame_last_s = col_last_s && (line_r == LINE_W'(HEIGHT - 1));
   assign issue_ok_s   = !ram_busy && (count_r <= 2'd1);
   assign push_s       = (state_r == S_CAPTURE);
   assign pop_s        = (count_r != 2'd0) && pix.ready;
   assign sof_s        = (line_r == {LINE_W{1'b0}}) && (col_r == {COL_W{1'b0}});
   assign head_s       = fifo_mem_r[rd_ptr_r];

   assign ram_addr   = addr_r;
   assign ram_hold   = ram_hold_r;
   assign busy       = busy_r;
   assign frame_done = done_r;
   assign pix.valid  = (count_r != 2'd0);
   assign pix.data   = head_s[DATA_W-1:0];
   assign pix.eol    = head_s[DATA_W];
   assign pix.sof    = head_s[DATA_W+1];

   // Scan-out FSM: raster counters, read handshake and frame bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_IDLE;
         col_r      <= {COL_W{1'b0}};
         line_r     <= {LINE_W{1'b0}};
         row_r      <= 8'd0;
         row_base_r <= {ADDR_W{1'b0}};
         addr_r     <= {ADDR_W{1'b0}};
         ram_hold_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         ram_hold_r <= 1'b0;
         done_r     <= 1'b0;
         case (state_r)
            S_IDLE: begin
               // A start landing on the frame_done cycle is deliberately dropped.
               if (start && !done_r) begin
                  row_r      <= start_row_s;
                  col_r      <= {COL_W{1'b0}};
                  line_r     <= {LINE_W{1'b0}};
                  row_base_r <= row_base_of(start_row_s);
                  addr_r     <= row_base_of(start_row_s);
                  busy_r     <= 1'b1;
                  state_r    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (issue_ok_s) begin
                  ram_hold_r <= 1'b1;
                  state_r    <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (col_last_s) begin
                  col_r  <= {COL_W{1'b0}};
                  line_r <= line_r + LINE_W'(1);
                  if (row_last_s) begin
                     row_r      <= 8'd0;
                     row_base_r <= {ADDR_W{1'b0}};
                     addr_r     <= {ADDR_W{1'b0}};
                  end else begin
                     row_r      <= row_r + 8'd1;
                     row_base_r <= row_base_r + ADDR_W'(WIDTH);
                     addr_r     <= row_base_r + ADDR_W'(WIDTH);
                  end
               end else begin
                  col_r  <= col_r + COL_W'(1);
                  addr_r <= addr_r + ADDR_W'(1);
               end
               state_r <= frame_last_s ? S_DRAIN : S_ISSUE;
            end
            S_DRAIN: begin
               if ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s)) begin
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Two-entry pixel FIFO holding {sof, eol, data}.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_mem_r[0] <= {ENT_W{1'b0}};
         fifo_mem_r[1] <= {ENT_W{1'b0}};
         wr_ptr_r      <= 1'b0;
         rd_ptr_r      <= 1'b0;
         count_r       <= 2'd0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {sof_s, col_last_s, ram_rdata};
            wr_ptr_r             <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_reader.sv
// Scoreboard bench for fb_reader on a reduced 16x12 frame; the RAM model
// returns addr[7:0] one cycle after the address, or 8'hEE while the writer owns it.
module tb_fb_reader;

   localparam int W = 16;
   localparam int H = 12;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  scroll_row;
   logic        ram_busy;
   logic [16:0] ram_addr;
   logic        ram_hold;
   logic [7:0]  ram_rdata;
   logic        busy;
   logic        frame_done;

   fb_reader_if #(.DATA_W(8)) pix_if ();

   fb_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(17), .DATA_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .scroll_row (scroll_row),
      .ram_busy   (ram_busy),
      .ram_addr   (ram_addr),
      .ram_hold   (ram_hold),
      .ram_rdata  (ram_rdata),
      .busy       (busy),
      .frame_done (frame_done),
      .pix        (pix_if)
   );

   always #5 clk = ~clk;

   // Registered RAM read port.
   always @(posedge clk) ram_rdata <= ram_busy ? 8'hEE : ram_addr[7:0];

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cnt = 0;
   int fetched_tot = 0;
   int accepted_tot = 0;
   int last_acc_cyc = -10;
   int fetch_base = 0;
   int acc_base = 0;
   logic [9:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_addr(input logic [7:0] s, input int k);
      int srow;
      int row;
      srow = (s >= 8'(H)) ? 0 : int'(s);
      row = (srow + k / W) % H;
      return row * W + k % W;
   endfunction

   function automatic logic [9:0] exp_pix(input logic [7:0] s, input int k);
      int a;
      logic [7:0] d;
      logic sof;
      logic eol;
      a = exp_addr(s, k);
      d = a[7:0];
      sof = (k == 0);
      eol = ((k % W) == W - 1);
      return {sof, eol, d};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: scoreboard pops, read-cycle counting and frame_done latency.
   always @(negedge clk) begin
      if (!reset) begin
         if (ram_hold) fetched_tot++;
         if (ram_busy) check("hold_while_busy", ram_hold, 1'b0);
         if (pix_if.valid && pix_if.ready) begin
            if (exp_q.size() == 0) begin
               check("pix_extra", exp_q.size(), 1);
            end else begin
               check("pix", {pix_if.sof, pix_if.eol, pix_if.data}, exp_q.pop_front());
            end
            accepted_tot++;
            last_acc_cyc = cyc;
         end
         if (frame_done) begin
            done_cnt++;
            check("done_latency", cyc - last_acc_cyc, 1);
            check("done_q_empty", exp_q.size(), 0);
         end
      end
   end

   task automatic start_frame(input logic [7:0] s);
      @(negedge clk);
      scroll_row = s;
      start = 1'b1;
      for (int k = 0; k < N; k++) exp_q.push_back(exp_pix(s, k));
      fetch_base = fetched_tot;
      acc_base = accepted_tot;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_acc(input int n);
      int k;
      k = 0;
      while ((accepted_tot - acc_base) < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("acc_timeout", (accepted_tot - acc_base) >= n, 1'b1);
   endtask

   // Returns on the negedge where frame_done is high (or on timeout).
   task automatic wait_done(input bit rnd);
      bit got;
      int k;
      got = 1'b0;
      k = 0;
      while (!got && k < 4000) begin
         @(posedge clk);
         #1;
         if (rnd) pix_if.ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (frame_done) got = 1'b1;
         k++;
      end
      check("frame_timeout", got, 1'b1);
      pix_if.ready = 1'b1;
   endtask

   initial begin
      int k;
      int ex_s;
      reset = 1'b1;
      start = 1'b0;
      scroll_row = 8'd0;
      ram_busy = 1'b0;
      pix_if.ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_addr", ram_addr, 0);
      check("rst_hold", ram_hold, 0);
      check("rst_valid", pix_if.valid, 0);
      check("rst_sof_eol", {pix_if.sof, pix_if.eol}, 0);
      check("rst_data", pix_if.data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);

      // Frame A: scroll 0, free-running consumer; start on the done cycle is dropped.
      start_frame(8'd0);
      wait_done(1'b0);
      scroll_row = 8'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_on_done_ignored", busy, 1'b0);
      check("done_one_cycle", frame_done, 1'b0);

      // Frame B: last-row scroll with writer contention, consumer stall and a stray start.
      start_frame(8'(H - 1));
      wait_acc(30);
      k = 0;
      while (ram_hold && k < 10) begin
         @(negedge clk);
         k++;
      end
      ram_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("busy_hold", ram_hold, 1'b0);
         check("busy_addr", ram_addr, exp_addr(8'(H - 1), fetched_tot - fetch_base));
      end
      ram_busy = 1'b0;
      wait_acc(60);
      @(posedge clk);
      #1;
      pix_if.ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i >= 10) begin
            check("stall_valid", pix_if.valid, 1'b1);
            check("stall_data", pix_if.data, exp_q[0][7:0]);
            check("stall_fill", (fetched_tot - fetch_base) - (accepted_tot - acc_base), 2);
            check("stall_addr", ram_addr, exp_addr(8'(H - 1), fetched_tot - fetch_base));
         end
      end
      @(posedge clk);
      #1;
      pix_if.ready = 1'b1;
      @(negedge clk);
      scroll_row = 8'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("midframe_start_busy", busy, 1'b1);
      wait_done(1'b0);

      // Frame C: out-of-range scroll acts as row 0, random backpressure.
      start_frame(8'd250);
      wait_done(1'b1);

      // Frame D: reset mid-frame.
      start_frame(8'd3);
      wait_acc(100);
      ex_s = done_cnt;
      reset = 1'b1;
      #1;
      check("rst_mid_valid", pix_if.valid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_done", frame_done, 1'b0);
      check("rst_mid_hold", ram_hold, 1'b0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      check("rst_no_done", done_cnt, ex_s);

      // Frame E: clean frame after the reset.
      start_frame(8'd7);
      wait_done(1'b0);

      repeat (5) @(negedge clk);
      check("done_count", done_cnt, 4);
      check("final_q_empty", exp_q.size(), 0);
      check("final_busy", busy, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_reader.md
Name: fb_reader

Overview:
- Scan-out reader for the 320x240, 8-bit-per-pixel SPRAM framebuffer.
- Walks the framebuffer in raster order, starting at a programmable scroll row and wrapping at row 239, so the waterfall appears to scroll.
- Arbitrates politely with the framebuffer writer and streams pixels to the display driver over a valid/ready interface.
- Sits between the framebuffer RAM port mux and the LCD driver.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame.
- ADDR_W, 17, framebuffer address width.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a frame; ignored while busy=1.
- scroll_row  in  8  first displayed row; sampled on an accepted start; a value >= HEIGHT is treated as 0.
- ram_busy  in  1  writer owns the RAM port this cycle.
- ram_addr  out  ADDR_W  read address toward the RAM port mux.
- ram_hold  out  1  writer must not take the port this cycle (reader capture cycle).
- ram_rdata  in  DATA_W  demuxed RAM read data.
- pix_data  out  DATA_W  pixel at the FIFO head.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  consumer accepts the pixel when pix_valid & pix_ready.
- pix_sof  out  1  head pixel is line 0, column 0 of the frame.
- pix_eol  out  1  head pixel is column WIDTH-1.
- busy  out  1  frame in progress.
- frame_done  out  1  single-cycle pulse when the last pixel is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, all counters 0.
- RAM timing:
  - Read data is registered and the data demux decodes the address that is live in the return cycle.
  - Each read therefore occupies 2 cycles with ram_addr held constant: ISSUE, then CAPTURE.
  - ram_hold=1 during CAPTURE only.
  - Peak rate is one pixel per 2 clocks.
- States:
  - IDLE: on start, load row=scroll_row (or 0), col=0, line=0, and row_base=row*WIDTH (computed with shift-add: row*256 + row*64). Set busy=1 and go to ISSUE.
  - ISSUE: ram_addr=row_base+col. Proceed only if ram_busy=0 and (fifo_count + 1) <= 2. Otherwise stay in ISSUE; no read is counted.
  - CAPTURE: write ram_rdata into the FIFO with tags sof=(line==0 && col==0) and eol=(col==WIDTH-1). Then advance the counters:
    - col wraps WIDTH-1 -> 0.
    - On wrap, line increments and row increments.
    - When row reaches HEIGHT it becomes 0 with row_base=0; otherwise row_base += WIDTH.
    - After the pixel at line HEIGHT-1, col WIDTH-1, go to DRAIN; otherwise go to ISSUE.
  - DRAIN: wait until the FIFO is empty and the final pixel has been accepted. Pulse frame_done for 1 cycle, clear busy, go to IDLE.
- FIFO:
  - 2 entries; each entry holds {sof, eol, data}.
  - pix_* reflect the head entry combinationally from registers.
  - A simultaneous push in CAPTURE and pop by the consumer is legal and keeps the count.
  - Overflow is impossible by the ISSUE gating rule; pop when empty is ignored.
- Address arithmetic: unsigned ADDR_W bits; the maximum address is 76799; no other wrap.
- Exactly WIDTH*HEIGHT pixels per frame, each emitted once, in order.
- Consumer stall is unbounded; the reader simply stops issuing.
- start during busy: ignored, and scroll_row is not resampled.
- start on the same cycle as frame_done: ignored; start must be asserted again from IDLE.
- Asynchronous reset mid-frame: immediate return to IDLE, FIFO flushed, pix_valid=0, no frame_done pulse.

Test Plan:
- Reset, start with scroll_row=0, RAM model returning addr[7:0], pix_ready=1 → 76800 pixels, first pixel 0x00 with pix_sof=1; pix_eol on every 320th pixel; frame_done exactly once, 1 cycle after the last accept; ~153600 cycles total.
- scroll_row=239 → first pixel is from address 76480 (sof=1); the 321st pixel is from address 0; the last line is from row 238 (address 76160..76479).
- ram_busy=1 for 10 cycles while in ISSUE → ram_addr holds the same value, no FIFO push, stream resumes in order with no lost or duplicated pixel; ram_hold never asserts while ram_busy=1 starts.
- pix_ready=0 for 50 cycles mid-line → FIFO fills to 2, reader stalls in ISSUE, pix_data stable; on release, order is preserved.
- start pulsed mid-frame with scroll_row=5 → ignored; the frame completes using the original scroll; scroll_row=250 → behaves as 0.
- Reset asserted at pixel 1000 → same cycle: pix_valid=0, busy=0; a new start afterwards yields a clean frame beginning with sof=1.
